// File: rtl/wtc_7seg_arbiter_pkg.sv
// Shared types and widths for the 7-segment display arbiter.
// Nibble/mode widths match the wtc_7seg driver inputs.
package wtc_7seg_arbiter_pkg;

    localparam int NUM_W  = 4;
    localparam int MODE_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_SHOW
    } state_e;

endpackage

// File: rtl/wtc_rr_pick.sv
// Combinational round-robin picker.
// Searches upward from (ptr_i + 1) mod N, skipping masked requesters.
module wtc_rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     mask_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;

    // First eligible requester after the pointer wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (!valid_o && req_i[cand] && !mask_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/wtc_7seg_arbiter.sv
// Time-shares one wtc_7seg driver among NUM_REQ requesters.
// Each grant latches its nibble/mode and holds it for DWELL_CYCLES clocks.
module wtc_7seg_arbiter
    import wtc_7seg_arbiter_pkg::*;
#(
    parameter int                NUM_REQ      = 4,
    parameter int                DWELL_CYCLES = 25000000,
    parameter logic [NUM_W-1:0]  IDLE_NUM     = 4'h0,
    parameter logic [MODE_W-1:0] IDLE_MODE    = 3'd0
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic [NUM_REQ-1:0]        i_Req,
    input  logic [NUM_W*NUM_REQ-1:0]  i_Num,
    input  logic [MODE_W*NUM_REQ-1:0] i_Mode,
    output logic [NUM_REQ-1:0]        o_Grant,
    output logic [NUM_REQ-1:0]        o_Done,
    output logic [NUM_W-1:0]          o_Binary_Num,
    output logic [MODE_W-1:0]         o_Mode,
    output logic                      o_Busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_W-1:0]    num_q, num_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic                busy_q, busy_d;
    logic [PTR_W-1:0]    idx_q, idx_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;

    logic                in_show;
    logic                finish;
    logic [NUM_REQ-1:0]  pick_mask;
    logic [PTR_W-1:0]    pick_ptr;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_valid;
    logic [NUM_W-1:0]    sel_num;
    logic [MODE_W-1:0]   sel_mode;

    // In SHOW the finishing owner is masked and the search starts after it.
    assign in_show   = (state_q == ST_SHOW);
    assign pick_mask = in_show ? grant_q : '0;
    assign pick_ptr  = in_show ? idx_q : ptr_q;

    wtc_rr_pick #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req_i   (i_Req),
        .mask_i  (pick_mask),
        .ptr_i   (pick_ptr),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Select the winner's nibble and mode for latching.
    always_comb begin
        sel_num  = '0;
        sel_mode = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_grant[k]) begin
                sel_num  = i_Num[k*NUM_W +: NUM_W];
                sel_mode = i_Mode[k*MODE_W +: MODE_W];
            end
        end
    end

    // Next-state: dwell counting, completion pulse and (re)arbitration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        num_d   = num_q;
        mode_d  = mode_q;
        busy_d  = busy_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        finish  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
            end
            ST_SHOW: begin
                if (cnt_q == CNT_LAST) begin
                    finish = 1'b1;
                    done_d = grant_q;
                    ptr_d  = idx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (!in_show || finish) begin
            cnt_d = '0;
            if (pick_valid) begin
                state_d = ST_SHOW;
                grant_d = pick_grant;
                idx_d   = pick_idx;
                num_d   = sel_num;
                mode_d  = sel_mode;
                busy_d  = 1'b1;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                num_d   = IDLE_NUM;
                mode_d  = IDLE_MODE;
                busy_d  = 1'b0;
            end
        end
    end

    // State register; reset aborts any grant without a done pulse.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            num_q   <= IDLE_NUM;
            mode_q  <= IDLE_MODE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= PTR_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_Grant      = grant_q;
    assign o_Done       = done_q;
    assign o_Binary_Num = num_q;
    assign o_Mode       = mode_q;
    assign o_Busy       = busy_q;

endmodule

// File: tb/tb_wtc_7seg_arbiter.sv
// Scoreboard bench for wtc_7seg_arbiter.
// A grant/dwell reference model feeds expected events to a monitor.
module tb_wtc_7seg_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [4*N-1:0] num;
    logic [3*N-1:0] mode;
    logic [N-1:0]   o_Grant;
    logic [N-1:0]   o_Done;
    logic [3:0]     o_Binary_Num;
    logic [2:0]     o_Mode;
    logic           o_Busy;

    wtc_7seg_arbiter #(
        .NUM_REQ      (N),
        .DWELL_CYCLES (D),
        .IDLE_NUM     (4'h0),
        .IDLE_MODE    (3'd0)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_Req        (req),
        .i_Num        (num),
        .i_Mode       (mode),
        .o_Grant      (o_Grant),
        .o_Done       (o_Done),
        .o_Binary_Num (o_Binary_Num),
        .o_Mode       (o_Mode),
        .o_Busy       (o_Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [3:0] num;
        logic [2:0] mode;
        int         cyc;
    } ev_t;

    ev_t gq[$];
    ev_t dq[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;

    int owner = -1;
    int rem   = 0;
    int last  = N - 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: an owner shows for D edges, then the next
    // requester after it in circular order (itself excluded) takes over.
    always @(posedge clk) begin
        int  excl;
        bit  pick;
        int  k;
        cyc++;
        if (rst) begin
            owner = -1;
            rem   = 0;
            last  = N - 1;
        end else begin
            excl = -1;
            pick = 1'b0;
            if (owner < 0) begin
                pick = 1'b1;
            end else begin
                rem--;
                if (rem == 0) begin
                    dq.push_back('{owner, 4'h0, 3'd0, cyc});
                    last  = owner;
                    excl  = owner;
                    owner = -1;
                    pick  = 1'b1;
                end
            end
            if (pick) begin
                for (int s = 1; s <= N; s++) begin
                    k = (last + s) % N;
                    if (owner < 0 && req[k] && k != excl) begin
                        owner = k;
                        rem   = D;
                        gq.push_back('{k, num[k*4 +: 4], mode[k*3 +: 3], cyc});
                    end
                end
            end
        end
    end

    ev_t         cur = '{0, 4'h0, 3'd0, 0};
    logic [N-1:0] prevg = '0;

    // Monitor: pops expected events when the DUT shows a grant or done.
    always @(negedge clk) begin
        ev_t e;
        if (cyc > 0) begin
            if (o_Done != 0) begin
                if (dq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got %b expected none at cycle %0d",
                             o_Done, cyc);
                end else begin
                    e = dq.pop_front();
                    chk("done_onehot", 32'(o_Done), 32'(1 << e.idx));
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            if (o_Grant != 0 && o_Grant != prevg) begin
                if (gq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL grant_unexpected: got %b expected none at cycle %0d",
                             o_Grant, cyc);
                end else begin
                    e = gq.pop_front();
                    chk("grant_onehot", 32'(o_Grant), 32'(1 << e.idx));
                    chk("grant_cycle", cyc, e.cyc);
                    cur = e;
                end
            end
            if (o_Grant != 0) begin
                chk("hold_num", 32'(o_Binary_Num), 32'(cur.num));
                chk("hold_mode", 32'(o_Mode), 32'(cur.mode));
                chk("busy_on", 32'(o_Busy), 32'd1);
            end else begin
                chk("idle_num", 32'(o_Binary_Num), 32'd0);
                chk("idle_mode", 32'(o_Mode), 32'd0);
                chk("busy_off", 32'(o_Busy), 32'd0);
            end
            prevg = o_Grant;
        end
    end

    task automatic wait_done(int k, int lim);
        int n;
        n = 0;
        while (!o_Done[k] && n < lim) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!o_Done[k]) begin
            fails++;
            $display("FAIL wait_done%0d: got no pulse expected pulse within %0d cycles",
                     k, lim);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = '0;
        num  = '0;
        mode = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Lone requester 2 is regranted after one idle cycle.
        num[8 +: 4]  = 4'hA;
        mode[6 +: 3] = 3'd3;
        req          = 4'b0100;
        wait_done(2, 20);
        @(negedge clk);
        wait_done(2, 20);
        req = '0;
        repeat (3) @(negedge clk);

        // Three simultaneous requesters served 0, 1, 3 back to back.
        pulse_reset();
        num  = 16'h7_0_2_1;
        mode = 12'o5_0_2_1;
        req  = 4'b1011;
        wait_done(0, 20);
        req[0] = 1'b0;
        @(negedge clk);
        wait_done(1, 20);
        req[1] = 1'b0;
        @(negedge clk);
        wait_done(3, 20);
        req[3] = 1'b0;
        repeat (3) @(negedge clk);

        // Two requesters held continuously alternate with no gaps.
        req = 4'b0011;
        repeat (4 * D + 2) @(negedge clk);
        req = '0;
        repeat (2 * D) @(negedge clk);

        // Data and request changes during SHOW are ignored.
        num[4 +: 4] = 4'h5;
        req         = 4'b0010;
        repeat (2) @(negedge clk);
        num[4 +: 4] = 4'h9;
        req[1]      = 1'b0;
        wait_done(1, 20);
        repeat (3) @(negedge clk);

        // Reset mid-SHOW aborts without done; requester 1 wins after.
        num[8 +: 4] = 4'hC;
        req         = 4'b0100;
        repeat (3) @(negedge clk);
        req = 4'b0110;
        pulse_reset();
        wait_done(1, 20);
        req[1] = 1'b0;
        @(negedge clk);
        wait_done(2, 20);
        req = '0;
        repeat (3) @(negedge clk);

        // Random traffic following the hold-until-done protocol.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < N; k++) begin
                if (req[k] && o_Done[k]) begin
                    req[k] = 1'($urandom_range(0, 1));
                end else if (!req[k] && $urandom_range(0, 5) == 0) begin
                    req[k]         = 1'b1;
                    num[k*4 +: 4]  = 4'($urandom);
                    mode[k*3 +: 3] = 3'($urandom);
                end else if (req[k] && $urandom_range(0, 99) == 0) begin
                    req[k] = 1'b0;
                end
                if ($urandom_range(0, 15) == 0) begin
                    num[k*4 +: 4] = 4'($urandom);
                end
            end
        end

        @(negedge clk);
        rst = 1'b0;
        req = '0;
        repeat (30) @(negedge clk);
        chk("grant_queue_empty", gq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
